exu_csrarb: RTL

//  Sequencer and arbiter for the single CSR file port. Shares it between the EXU CSR-instruction

---
 rtl/exu_csrarb_pkg.sv | 8 +
 rtl/exu_csrarb_wgen.sv | 13 +
 rtl/exu_csrarb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/exu_csrarb_pkg.sv
// exu_csrarb_pkg: op/state encodings and requester indices shared by the CSR port arbiter.
package exu_csrarb_pkg;
   typedef enum logic [1:0] {OP_RD = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RD = 2'b01, ST_WR = 2'b10, ST_RSP = 2'b11} state_e;
   localparam int OWN_EXU = 0;
   localparam int OWN_TRP = 1;
   localparam int OWN_DBG = 2;
endpackage

// File: rtl/exu_csrarb_wgen.sv
// exu_csrarb_wgen: combinational read-modify-write data for CSR RW/RS/RC ops.
module exu_csrarb_wgen
   import exu_csrarb_pkg::*;
#(
   parameter int DW = 32
) (
   input  csr_op_e         op,
   input  logic [DW-1:0]   opn,
   input  logic [DW-1:0]   old,
   output logic [DW-1:0]   wdat
);
   always_comb wdat = op == OP_RS ? (opn | old) : op == OP_RC ? (~opn & old) : opn;
endmodule

// File: rtl/exu_csrarb.sv
// exu_csrarb: fixed-priority sequencer for the single CSR file port (read, RMW write, response).
// CIRNO_CSR_DBG_PORT_EN adds a debug requester above trap and EXU.
module exu_csrarb
   import exu_csrarb_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            exu_req_val,
   output logic            exu_req_rdy,
   input  logic [1:0]      exu_req_op,
   input  logic [AW-1:0]   exu_req_idx,
   input  logic [DW-1:0]   exu_req_opn,
   output logic            exu_rsp_val,
   input  logic            exu_rsp_rdy,
   output logic [DW-1:0]   exu_rsp_dat,
   input  logic            trp_req_val,
   output logic            trp_req_rdy,
   input  logic [1:0]      trp_req_op,
   input  logic [AW-1:0]   trp_req_idx,
   input  logic [DW-1:0]   trp_req_opn,
   output logic            trp_rsp_val,
   input  logic            trp_rsp_rdy,
   output logic [DW-1:0]   trp_rsp_dat,
`ifdef CIRNO_CSR_DBG_PORT_EN
   input  logic            dbg_req_val,
   output logic            dbg_req_rdy,
   input  logic [1:0]      dbg_req_op,
   input  logic [AW-1:0]   dbg_req_idx,
   input  logic [DW-1:0]   dbg_req_opn,
   output logic            dbg_rsp_val,
   input  logic            dbg_rsp_rdy,
   output logic [DW-1:0]   dbg_rsp_dat,
`endif
   output logic            csr_ren,
   output logic            csr_wen,
   output logic [AW-1:0]   csr_idx,
   output logic [DW-1:0]   csr_wdat,
   input  logic [DW-1:0]   csr_rdat
);
`ifdef CIRNO_CSR_DBG_PORT_EN
   localparam int NP = 3;
`else
   localparam int NP = 2;
`endif
   localparam int OW = $clog2(NP);
   localparam logic [NP-1:0] ONE = NP'(1);
   logic [NP-1:0] req_val, rsp_rdy, gnt, rsp_q;
   csr_op_e req_op [NP];
   logic [AW-1:0] req_idx [NP];
   logic [DW-1:0] req_opn [NP];
   state_e state;
   csr_op_e op_q;
   logic [OW-1:0] own, sel;
   logic [AW-1:0] idx_q;
   logic [DW-1:0] opn_q, old_q, wdat_q, wgen_dat, rsp_dat;
   logic ren_q, wen_q;
   assign req_val[OWN_EXU] = exu_req_val;
   assign rsp_rdy[OWN_EXU] = exu_rsp_rdy;
   assign req_op[OWN_EXU]  = csr_op_e'(exu_req_op);
   assign req_idx[OWN_EXU] = exu_req_idx;
   assign req_opn[OWN_EXU] = exu_req_opn;
   assign req_val[OWN_TRP] = trp_req_val;
   assign rsp_rdy[OWN_TRP] = trp_rsp_rdy;
   assign req_op[OWN_TRP]  = csr_op_e'(trp_req_op);
   assign req_idx[OWN_TRP] = trp_req_idx;
   assign req_opn[OWN_TRP] = trp_req_opn;
`ifdef CIRNO_CSR_DBG_PORT_EN
   assign req_val[OWN_DBG] = dbg_req_val;
   assign rsp_rdy[OWN_DBG] = dbg_rsp_rdy;
   assign req_op[OWN_DBG]  = csr_op_e'(dbg_req_op);
   assign req_idx[OWN_DBG] = dbg_req_idx;
   assign req_opn[OWN_DBG] = dbg_req_opn;
   assign dbg_req_rdy = gnt[OWN_DBG];
   assign dbg_rsp_val = rsp_q[OWN_DBG] & rst_n;
   assign dbg_rsp_dat = rsp_dat;
`endif
   // Requester index doubles as priority: the highest valid index wins.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NP; i++)
         if (req_val[i]) sel = OW'(i);
   end
   always_comb gnt = (rst_n && state == ST_IDLE && |req_val) ? ONE << sel : '0;
   // RMW data is formed from the live read so csr_wdat can be registered for the WR cycle.
   exu_csrarb_wgen #(.DW(DW)) u_wgen (
      .op   (op_q),
      .opn  (opn_q),
      .old  (csr_rdat),
      .wdat (wgen_dat)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         own    <= '0;
         op_q   <= OP_RD;
         idx_q  <= '0;
         opn_q  <= '0;
         old_q  <= '0;
         wdat_q <= '0;
         ren_q  <= 1'b0;
         wen_q  <= 1'b0;
         rsp_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|gnt) begin
               state <= ST_RD;
               own   <= sel;
               op_q  <= req_op[sel];
               idx_q <= req_idx[sel];
               opn_q <= req_opn[sel];
               ren_q <= 1'b1;
            end
            ST_RD: begin
               old_q  <= csr_rdat;
               wdat_q <= wgen_dat;
               ren_q  <= 1'b0;
               wen_q  <= op_q != OP_RD;
               state  <= op_q == OP_RD ? ST_RSP : ST_WR;
               rsp_q  <= op_q == OP_RD ? ONE << own : '0;
            end
            ST_WR: begin
               wen_q <= 1'b0;
               state <= ST_RSP;
               rsp_q <= ONE << own;
            end
            ST_RSP: if (rsp_rdy[own]) begin
               state <= ST_IDLE;
               rsp_q <= '0;
            end
         endcase
      end
   end
   // Reset masks outputs immediately so an in-flight write is dropped in the reset cycle.
   assign rsp_dat     = rst_n ? old_q : '0;
   assign exu_req_rdy = gnt[OWN_EXU];
   assign exu_rsp_val = rsp_q[OWN_EXU] & rst_n;
   assign exu_rsp_dat = rsp_dat;
   assign trp_req_rdy = gnt[OWN_TRP];
   assign trp_rsp_val = rsp_q[OWN_TRP] & rst_n;
   assign trp_rsp_dat = rsp_dat;
   assign csr_ren     = ren_q & rst_n;
   assign csr_wen     = wen_q & rst_n;
   assign csr_idx     = rst_n ? idx_q : '0;
   assign csr_wdat    = rst_n ? wdat_q : '0;
endmodule
